text_console_ctrl: RTL and testbench

TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

---
 rtl/text_console_ctrl_if.sv | 26 ++
 rtl/text_console_ctrl.sv | 143 ++++++++++++++
 tb/tb_text_console_ctrl.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_console_ctrl_if.sv
// rtl/text_console_ctrl_if.sv - character stream, clear request, VRAM write port and cursor bundle
interface text_console_ctrl_if;
    logic        char_valid_i;
    logic [7:0]  char_data_i;
    logic [7:0]  attr_i;
    logic        char_ready_o;
    logic        clear_i;
    logic        busy_o;
    logic        vram_cea_o;
    logic [10:0] vram_ada_o;
    logic [15:0] vram_din_o;
    logic [5:0]  cursor_x_o;
    logic [5:0]  cursor_y_o;

    modport master (
        output char_valid_i, char_data_i, attr_i, clear_i,
        input  char_ready_o, busy_o, vram_cea_o, vram_ada_o, vram_din_o,
               cursor_x_o, cursor_y_o
    );

    modport slave (
        input  char_valid_i, char_data_i, attr_i, clear_i,
        output char_ready_o, busy_o, vram_cea_o, vram_ada_o, vram_din_o,
               cursor_x_o, cursor_y_o
    );
endinterface

// File: rtl/text_console_ctrl.sv
// rtl/text_console_ctrl.sv - text console writer: cursor tracking, VRAM character writes, optional clear sweep
//   clk_i, rst_i (sync, active-high)
//   bus.char_valid_i/char_data_i/attr_i/char_ready_o : character byte stream
//   bus.clear_i/busy_o                               : clear-screen request, operation in progress
//   bus.vram_cea_o/vram_ada_o/vram_din_o             : VRAM write port, din = {attr, char}
//   bus.cursor_x_o/cursor_y_o                        : current cursor column/row
//   Clear engine present only when TEXT_CONSOLE_CLEAR_EN is defined.
module text_console_ctrl #(
    parameter int         COLS       = 60,
    parameter int         ROWS       = 34,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input logic                clk_i,
    input logic                rst_i,
    text_console_ctrl_if.slave bus
);

    localparam logic [5:0] LAST_X = 6'(COLS - 1);
    localparam logic [5:0] LAST_Y = 6'(ROWS - 1);

`ifdef TEXT_CONSOLE_CLEAR_EN
    localparam logic [10:0] LAST_CELL = 11'(COLS * ROWS - 1);
    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

    state_t      state_q, state_d;
    logic [5:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;
    logic        cea_q, cea_d;
    logic [10:0] ada_q, ada_d;
    logic [15:0] din_q, din_d;
    logic        busy_q;

    logic [10:0] cell_addr;
    logic [5:0]  next_y;
    logic        printable;

    assign cell_addr = 11'(int'(y_q) * COLS + int'(x_q));
    assign next_y    = (y_q == LAST_Y) ? 6'd0 : y_q + 6'd1;
    assign printable = (bus.char_data_i >= 8'h20) && (bus.char_data_i <= 8'h7E);

`ifdef TEXT_CONSOLE_CLEAR_EN
    assign bus.char_ready_o = (state_q == IDLE) && !bus.clear_i && !rst_i;
`else
    assign bus.char_ready_o = (state_q == IDLE) && !rst_i;
    logic unused_clear;
    assign unused_clear = ^{bus.clear_i, BLANK_CHAR};
`endif

    assign bus.busy_o     = busy_q;
    assign bus.vram_cea_o = cea_q;
    assign bus.vram_ada_o = ada_q;
    assign bus.vram_din_o = din_q;
    assign bus.cursor_x_o = x_q;
    assign bus.cursor_y_o = y_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            x_q     <= 6'd0;
            y_q     <= 6'd0;
            cea_q   <= 1'b0;
            ada_q   <= 11'd0;
            din_q   <= 16'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cea_q   <= cea_d;
            ada_q   <= ada_d;
            din_q   <= din_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // ada/din hold their value unless a write is launched; during a sweep the
    // address register doubles as the sweep counter and din keeps the latched attr.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cea_d   = 1'b0;
        ada_d   = ada_q;
        din_d   = din_q;
        case (state_q)
            IDLE: begin
`ifdef TEXT_CONSOLE_CLEAR_EN
                if (bus.clear_i) begin
                    state_d = CLEAR;
                    cea_d   = 1'b1;
                    ada_d   = 11'd0;
                    din_d   = {bus.attr_i, BLANK_CHAR};
                end else if (bus.char_valid_i) begin
`else
                if (bus.char_valid_i) begin
`endif
                    if (printable) begin
                        state_d = WRITE;
                        cea_d   = 1'b1;
                        ada_d   = cell_addr;
                        din_d   = {bus.attr_i, bus.char_data_i};
                    end else begin
                        case (bus.char_data_i)
                            8'h0D: x_d = 6'd0;
                            8'h0A: begin
                                x_d = 6'd0;
                                y_d = next_y;
                            end
                            8'h08: if (x_q != 6'd0) x_d = x_q - 6'd1;
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
                if (x_q == LAST_X) begin
                    x_d = 6'd0;
                    y_d = next_y;
                end else begin
                    x_d = x_q + 6'd1;
                end
            end
`ifdef TEXT_CONSOLE_CLEAR_EN
            CLEAR: begin
                if (ada_q == LAST_CELL) begin
                    state_d = IDLE;
                    x_d     = 6'd0;
                    y_d     = 6'd0;
                end else begin
                    cea_d = 1'b1;
                    ada_d = ada_q + 11'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// tb/tb_text_console_ctrl.sv - randomized self-checking bench for text_console_ctrl against a screen/cursor model
module tb_text_console_ctrl;

    localparam int COLS  = 60;
    localparam int ROWS  = 34;
    localparam int CELLS = COLS * ROWS;

    logic clk = 1'b0;
    logic rst = 1'b1;

    text_console_ctrl_if bus ();

    text_console_ctrl #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .BLANK_CHAR (8'h20)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int mx = 0;
    int my = 0;
    int strobes = 0;
    logic [15:0] model_screen [CELLS];
    logic [15:0] dut_screen   [CELLS];
    logic [10:0] obs_ada;
    logic [15:0] obs_din;

    always begin
        @(posedge clk);
        #2;
        if (bus.vram_cea_o === 1'b1) begin
            strobes++;
            if (int'(bus.vram_ada_o) < CELLS) dut_screen[bus.vram_ada_o] = bus.vram_din_o;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic bit is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

    function automatic void model_advance();
        int pos;
        pos = (my * COLS + mx + 1) % CELLS;
        mx  = pos % COLS;
        my  = pos / COLS;
    endfunction

    function automatic void model_control(input logic [7:0] c);
        case (c)
            8'h0D: mx = 0;
            8'h0A: begin mx = 0; my = (my + 1) % ROWS; end
            8'h08: if (mx > 0) mx = mx - 1;
            default: ;
        endcase
    endfunction

    function automatic logic [7:0] rand_printable();
        return 8'($urandom_range(32'h20, 32'h7E));
    endfunction

    function automatic logic [7:0] rand_code();
        logic [7:0] c;
        case ($urandom_range(0, 9))
            0: c = 8'h08;
            1: c = 8'h0D;
            2: c = 8'h0A;
            3: begin
                c = 8'($urandom_range(0, 31));
                if (c == 8'h08 || c == 8'h0A || c == 8'h0D) c = 8'h7F;
            end
            4: c = 8'($urandom_range(32'h7F, 32'hFF));
            default: c = rand_printable();
        endcase
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] code, input logic [7:0] attr);
        int wait_cyc = 0;
        logic [10:0] exp_ada;
        @(negedge clk);
        bus.char_valid_i = 1'b1;
        bus.char_data_i  = code;
        bus.attr_i       = attr;
        #1;
        while (bus.char_ready_o !== 1'b1 && wait_cyc < 8) begin
            @(negedge clk);
            #1;
            wait_cyc++;
        end
        n_checks++;
        if (bus.char_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL send_ready: ready=%b required 1 (code %02h)", bus.char_ready_o, code);
            bus.char_valid_i = 1'b0;
            return;
        end
        @(negedge clk);
        bus.char_valid_i = 1'b0;
        #1;
        if (is_printable(code)) begin
            exp_ada = 11'(my * COLS + mx);
            obs_ada = bus.vram_ada_o;
            obs_din = bus.vram_din_o;
            n_checks++;
            if (bus.vram_cea_o !== 1'b1 || obs_ada !== exp_ada || obs_din !== {attr, code}) begin
                n_errors++;
                $display("FAIL write_cycle: cea=%b ada=%0d din=%04h required cea=1 ada=%0d din=%04h",
                         bus.vram_cea_o, obs_ada, obs_din, exp_ada, {attr, code});
            end
            n_checks++;
            if (bus.char_ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin
                n_errors++;
                $display("FAIL write_flags: ready=%b busy=%b required ready=0 busy=1",
                         bus.char_ready_o, bus.busy_o);
            end
            model_screen[exp_ada] = {attr, code};
            model_advance();
            @(negedge clk);
            #1;
        end else begin
            model_control(code);
        end
        n_checks++;
        if (bus.vram_cea_o !== 1'b0 || bus.char_ready_o !== 1'b1 || bus.busy_o !== 1'b0 ||
            bus.cursor_x_o !== 6'(mx) || bus.cursor_y_o !== 6'(my)) begin
            n_errors++;
            $display("FAIL after_byte %02h: cea=%b ready=%b busy=%b cursor=(%0d,%0d) required 0,1,0 (%0d,%0d)",
                     code, bus.vram_cea_o, bus.char_ready_o, bus.busy_o,
                     bus.cursor_x_o, bus.cursor_y_o, mx, my);
        end
    endtask

    task automatic test_reset();
        bus.char_valid_i = 1'b0;
        bus.char_data_i  = 8'h00;
        bus.attr_i       = 8'h00;
        bus.clear_i      = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (bus.char_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ready: ready=%b required 0", bus.char_ready_o);
        end
        n_checks++;
        if (bus.vram_cea_o !== 1'b0 || bus.vram_ada_o !== 11'd0 || bus.vram_din_o !== 16'd0 || bus.busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: cea=%b ada=%0d din=%04h busy=%b required all 0",
                     bus.vram_cea_o, bus.vram_ada_o, bus.vram_din_o, bus.busy_o);
        end
        n_checks++;
        if (bus.cursor_x_o !== 6'd0 || bus.cursor_y_o !== 6'd0) begin
            n_errors++;
            $display("FAIL reset_cursor: (%0d,%0d) required (0,0)", bus.cursor_x_o, bus.cursor_y_o);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.char_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL post_reset_ready: ready=%b required 1", bus.char_ready_o);
        end
        mx = 0;
        my = 0;
    endtask

    task automatic test_printable();
        send_byte(8'h41, 8'h1F);
        n_checks++;
        if (obs_ada !== 11'd0 || obs_din !== 16'h1F41 || bus.cursor_x_o !== 6'd1 || bus.cursor_y_o !== 6'd0) begin
            n_errors++;
            $display("FAIL printable_A: ada=%0d din=%04h cursor=(%0d,%0d) required 0 1F41 (1,0)",
                     obs_ada, obs_din, bus.cursor_x_o, bus.cursor_y_o);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 58; i++) send_byte(rand_printable(), 8'($urandom));
        send_byte(8'h78, 8'h2A);
        n_checks++;
        if (obs_ada !== 11'd59 || bus.cursor_x_o !== 6'd0 || bus.cursor_y_o !== 6'd1) begin
            n_errors++;
            $display("FAIL row_wrap: ada=%0d cursor=(%0d,%0d) required 59 (0,1)",
                     obs_ada, bus.cursor_x_o, bus.cursor_y_o);
        end
        for (int i = 0; i < 32; i++) send_byte(8'h0A, 8'h00);
        for (int i = 0; i < 59; i++) send_byte(rand_printable(), 8'($urandom));
        send_byte(8'h78, 8'h4E);
        n_checks++;
        if (obs_ada !== 11'd2039 || bus.cursor_x_o !== 6'd0 || bus.cursor_y_o !== 6'd0) begin
            n_errors++;
            $display("FAIL screen_wrap: ada=%0d cursor=(%0d,%0d) required 2039 (0,0)",
                     obs_ada, bus.cursor_x_o, bus.cursor_y_o);
        end
    endtask

    task automatic test_control();
        logic [7:0] codes [3];
        int exp_x [3];
        int exp_y [3];
        int s0;
        codes[0] = 8'h08; codes[1] = 8'h0D; codes[2] = 8'h0A;
        exp_x[0] = 9;     exp_x[1] = 0;     exp_x[2] = 0;
        exp_y[0] = 5;     exp_y[1] = 5;     exp_y[2] = 6;
        for (int i = 0; i < 5; i++) send_byte(8'h0A, 8'h00);
        for (int i = 0; i < 10; i++) send_byte(rand_printable(), 8'($urandom));
        s0 = strobes;
        @(negedge clk);
        bus.char_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.char_data_i = codes[i];
            #1;
            n_checks++;
            if (bus.char_ready_o !== 1'b1) begin
                n_errors++;
                $display("FAIL ctrl_ready[%0d]: ready=%b required 1", i, bus.char_ready_o);
            end
            @(negedge clk);
            if (i == 2) bus.char_valid_i = 1'b0;
            #1;
            model_control(codes[i]);
            n_checks++;
            if (bus.cursor_x_o !== 6'(exp_x[i]) || bus.cursor_y_o !== 6'(exp_y[i]) || bus.vram_cea_o !== 1'b0) begin
                n_errors++;
                $display("FAIL ctrl_cursor[%0d]: cursor=(%0d,%0d) cea=%b required (%0d,%0d) cea=0",
                         i, bus.cursor_x_o, bus.cursor_y_o, bus.vram_cea_o, exp_x[i], exp_y[i]);
            end
        end
        n_checks++;
        if (strobes != s0) begin
            n_errors++;
            $display("FAIL ctrl_no_strobe: strobes=%0d required 0", strobes - s0);
        end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) send_byte(rand_code(), 8'($urandom));
    endtask

    task automatic test_back_to_back(input int n);
        int acc = 0;
        int cyc = 0;
        int last_acc = 0;
        int s0;
        logic [7:0] c;
        logic [7:0] a;
        s0 = strobes;
        c = rand_printable();
        a = 8'($urandom);
        @(negedge clk);
        bus.char_valid_i = 1'b1;
        while (acc < n && cyc < 4 * n) begin
            bus.char_data_i = c;
            bus.attr_i      = a;
            #1;
            if (bus.char_ready_o === 1'b1) begin
                model_screen[my * COLS + mx] = {a, c};
                model_advance();
                acc++;
                last_acc = cyc;
                c = rand_printable();
                a = 8'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        bus.char_valid_i = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (acc != n || last_acc != 2 * (n - 1)) begin
            n_errors++;
            $display("FAIL b2b_rate: accepted=%0d last_cycle=%0d required %0d %0d", acc, last_acc, n, 2 * (n - 1));
        end
        n_checks++;
        if (strobes - s0 != n) begin
            n_errors++;
            $display("FAIL b2b_strobes: %0d required %0d", strobes - s0, n);
        end
        n_checks++;
        if (bus.cursor_x_o !== 6'(mx) || bus.cursor_y_o !== 6'(my)) begin
            n_errors++;
            $display("FAIL b2b_cursor: (%0d,%0d) required (%0d,%0d)", bus.cursor_x_o, bus.cursor_y_o, mx, my);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] c;
        int s1;
        c = rand_printable();
        @(negedge clk);
        bus.char_valid_i = 1'b1;
        bus.char_data_i  = c;
        bus.attr_i       = 8'h5C;
        @(negedge clk);
        bus.char_valid_i = 1'b0;
        model_screen[my * COLS + mx] = {8'h5C, c};
        rst = 1'b1;
        @(negedge clk);
        #1;
        s1 = strobes;
        n_checks++;
        if (bus.vram_cea_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.cursor_x_o !== 6'd0 ||
            bus.cursor_y_o !== 6'd0 || bus.char_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_write: cea=%b busy=%b cursor=(%0d,%0d) ready=%b required 0 0 (0,0) 0",
                     bus.vram_cea_o, bus.busy_o, bus.cursor_x_o, bus.cursor_y_o, bus.char_ready_o);
        end
        rst = 1'b0;
        mx = 0;
        my = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (strobes != s1) begin
            n_errors++;
            $display("FAIL rst_write_no_strobe: extra strobes=%0d required 0", strobes - s1);
        end
    endtask

`ifdef TEXT_CONSOLE_CLEAR_EN
    task automatic test_clear_collision();
        int busy_cyc = 0;
        int bad = 0;
        @(negedge clk);
        bus.clear_i      = 1'b1;
        bus.char_valid_i = 1'b1;
        bus.char_data_i  = 8'h5A;
        bus.attr_i       = 8'h07;
        #1;
        n_checks++;
        if (bus.char_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_collision_ready: ready=%b required 0", bus.char_ready_o);
        end
        @(negedge clk);
        bus.clear_i = 1'b0;
        #1;
        while (bus.busy_o === 1'b1 && busy_cyc < 3000) begin
            if (bus.vram_cea_o !== 1'b1 || bus.vram_ada_o !== 11'(busy_cyc) || bus.vram_din_o !== 16'h0720) bad++;
            busy_cyc++;
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (busy_cyc != CELLS || bad != 0) begin
            n_errors++;
            $display("FAIL clear_sweep: busy_cycles=%0d bad_strobes=%0d required %0d 0", busy_cyc, bad, CELLS);
        end
        n_checks++;
        if (bus.cursor_x_o !== 6'd0 || bus.cursor_y_o !== 6'd0 || bus.char_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_done: cursor=(%0d,%0d) ready=%b required (0,0) 1",
                     bus.cursor_x_o, bus.cursor_y_o, bus.char_ready_o);
        end
        for (int i = 0; i < CELLS; i++) model_screen[i] = 16'h0720;
        mx = 0;
        my = 0;
        @(negedge clk);
        bus.char_valid_i = 1'b0;
        #1;
        n_checks++;
        if (bus.vram_cea_o !== 1'b1 || bus.vram_ada_o !== 11'd0 || bus.vram_din_o !== 16'h075A) begin
            n_errors++;
            $display("FAIL clear_pending_byte: cea=%b ada=%0d din=%04h required 1 0 075A",
                     bus.vram_cea_o, bus.vram_ada_o, bus.vram_din_o);
        end
        model_screen[0] = 16'h075A;
        model_advance();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_clear();
        int cyc = 0;
        int s1;
        @(negedge clk);
        bus.clear_i = 1'b1;
        bus.attr_i  = 8'h3B;
        @(negedge clk);
        bus.clear_i = 1'b0;
        #1;
        while (!(bus.vram_cea_o === 1'b1 && bus.vram_ada_o === 11'd100) && cyc < 300) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (cyc >= 300) begin
            n_errors++;
            $display("FAIL rst_clear_reach: address 100 not reached in %0d cycles", cyc);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        s1 = strobes;
        n_checks++;
        if (bus.vram_cea_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.cursor_x_o !== 6'd0 || bus.cursor_y_o !== 6'd0) begin
            n_errors++;
            $display("FAIL rst_mid_clear: cea=%b busy=%b cursor=(%0d,%0d) required 0 0 (0,0)",
                     bus.vram_cea_o, bus.busy_o, bus.cursor_x_o, bus.cursor_y_o);
        end
        rst = 1'b0;
        for (int i = 0; i <= 100; i++) model_screen[i] = 16'h3B20;
        mx = 0;
        my = 0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (strobes != s1 || bus.busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_clear_resumed: extra strobes=%0d busy=%b required 0 0", strobes - s1, bus.busy_o);
        end
    endtask
`else
    task automatic test_clear_ignored();
        int s0;
        logic [7:0] c;
        c = rand_printable();
        s0 = strobes;
        @(negedge clk);
        bus.clear_i      = 1'b1;
        bus.char_valid_i = 1'b1;
        bus.char_data_i  = c;
        bus.attr_i       = 8'h07;
        #1;
        n_checks++;
        if (bus.char_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_ignored_ready: ready=%b required 1", bus.char_ready_o);
        end
        @(negedge clk);
        bus.char_valid_i = 1'b0;
        #1;
        n_checks++;
        if (bus.vram_cea_o !== 1'b1 || bus.vram_ada_o !== 11'(my * COLS + mx) || bus.vram_din_o !== {8'h07, c}) begin
            n_errors++;
            $display("FAIL clear_ignored_write: cea=%b ada=%0d din=%04h required 1 %0d %04h",
                     bus.vram_cea_o, bus.vram_ada_o, bus.vram_din_o, my * COLS + mx, {8'h07, c});
        end
        model_screen[my * COLS + mx] = {8'h07, c};
        model_advance();
        repeat (4) @(negedge clk);
        #1;
        bus.clear_i = 1'b0;
        n_checks++;
        if (strobes - s0 != 1 || bus.busy_o !== 1'b0 || bus.cursor_x_o !== 6'(mx) || bus.cursor_y_o !== 6'(my)) begin
            n_errors++;
            $display("FAIL clear_ignored_sweep: strobes=%0d busy=%b cursor=(%0d,%0d) required 1 0 (%0d,%0d)",
                     strobes - s0, bus.busy_o, bus.cursor_x_o, bus.cursor_y_o, mx, my);
        end
    endtask
`endif

    task automatic test_screen();
        int bad = 0;
        int first = -1;
        @(negedge clk);
        for (int i = 0; i < CELLS; i++) begin
            if (dut_screen[i] !== model_screen[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL screen_contents: %0d cells differ, first at %0d got %04h required %04h",
                     bad, first, dut_screen[first], model_screen[first]);
        end
    endtask

    initial begin
        for (int i = 0; i < CELLS; i++) begin
            model_screen[i] = 16'h0000;
            dut_screen[i]   = 16'h0000;
        end
        test_reset();
        test_printable();
        test_wrap();
        test_control();
        test_random(250);
        test_back_to_back(40);
        test_screen();
        test_reset_mid_write();
`ifdef TEXT_CONSOLE_CLEAR_EN
        test_clear_collision();
        test_random(60);
        test_reset_mid_clear();
`else
        test_clear_ignored();
`endif
        test_random(60);
        test_screen();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
